rv64_alu_regfile: RTL and testbench

- Execution datapath slice for the single-cycle RV64 core: a 32 x 64-bit integer register file plus a small 64-bit ALU.
- Register file: two combinational read ports and one synchronous write port.
- ALU: add or unsigned set-less-than, selected by a 2-bit one-hot op code.
- Sits between the decoder (which supplies addresses, immediates and op) and the PC/memory/writeback logic.

---
 rtl/rv64_alu_regfile.sv | 46 ++++
 tb/tb_rv64_alu_regfile.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv64_alu_regfile.sv
// Execution slice for the RV64 core: 32 x XLEN register file (2R/1W, x0 hardwired
// to zero) plus a combinational add / unsigned set-less-than ALU.
module rv64_alu_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  input  logic [1:0]      aluop,
  output logic [XLEN-1:0] alu_result
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // No write-through: reads see the stored value until the write edge.
  assign rdata1 = (rst || raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (rst || raddr2 == '0) ? '0 : regs[raddr2];

  always_comb begin
    alu_result = '0;
    case (aluop)
      2'b01:   alu_result = alu_src1 + alu_src2;
      2'b10:   alu_result = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
      default: alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_rv64_alu_regfile.sv
// Scoreboard bench for rv64_alu_regfile: stimulus pushes model expectations,
// a monitor on the falling edge pops and compares against the DUT outputs.
module tb_rv64_alu_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [63:0] rdata1, rdata2, wdata, alu_src1, alu_src2, alu_result;
  logic        we;
  logic [1:0]  aluop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0 rdata1, 1 rdata2, 2 alu_result
    int          tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  logic [63:0] mdl [32];

  rv64_alu_regfile dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .rdata1(rdata1),
    .raddr2(raddr2), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .aluop(aluop),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op == 2'd1) return a + b;
    if (op == 2'd2) return (a < b) ? 64'd1 : 64'd0;
    return 64'd0;
  endfunction

  function automatic logic [63:0] rd_ref(input logic [4:0] a);
    return (a == 5'd0) ? 64'd0 : mdl[a];
  endfunction

  task automatic push(input int kind, input int tag, input logic [63:0] exp);
    exp_t e;
    e.kind = kind; e.tag = tag; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic exp_rd1(input int tag);
    push(0, tag, rst ? 64'd0 : rd_ref(raddr1));
  endtask

  task automatic exp_rd2(input int tag);
    push(1, tag, rst ? 64'd0 : rd_ref(raddr2));
  endtask

  task automatic exp_alu(input int tag);
    push(2, tag, alu_ref(aluop, alu_src1, alu_src2));
  endtask

  // Advance one clock, committing any pending write into the model.
  task automatic step();
    if (we && !rst && waddr != 5'd0) mdl[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic alu_case(input int tag, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] want);
    aluop = op; alu_src1 = a; alu_src2 = b;
    push(2, tag, want);
    step();
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due at the next falling edge.
  initial begin
    exp_t e;
    logic [63:0] act;
    string nm;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          0:       begin act = rdata1;     nm = "rdata1"; end
          1:       begin act = rdata2;     nm = "rdata2"; end
          default: begin act = alu_result; nm = "alu_result"; end
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s tag=%0d got %h want %h", nm, e.tag, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b;
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; alu_src1 = '0; alu_src2 = '0; aluop = 2'b00;
    @(posedge clk); #1;
    raddr1 = 5'd7; raddr2 = 5'd31;
    exp_rd1(1); exp_rd2(2); exp_alu(3);
    step();
    rst = 1'b0;
    step();

    // Async reset clear
    do_write(5'd5, 64'hDEADBEEF);
    raddr1 = 5'd5;
    push(0, 10, 64'hDEADBEEF);
    step();
    #3 rst = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    push(0, 11, 64'd0);
    step();
    we = 1'b1; waddr = 5'd5; wdata = 64'h55;   // write during reset is lost
    step();
    we = 1'b0;
    #3 rst = 1'b0;
    push(0, 12, 64'd0);
    step();

    // Write/read, x0 discard
    do_write(5'd10, 64'h1234567887654321);
    raddr1 = 5'd10; exp_rd1(20);
    push(0, 21, 64'h1234567887654321);
    step();
    do_write(5'd0, 64'hFFFF);
    raddr2 = 5'd0; push(1, 22, 64'd0);
    step();

    // Reset in the same cycle as a write
    do_write(5'd9, 64'h99);
    we = 1'b1; waddr = 5'd9; wdata = 64'h1111;
    #3 rst = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    step();
    we = 1'b0;
    #3 rst = 1'b0;
    raddr1 = 5'd9; push(0, 25, 64'd0);
    step();

    // Same-cycle read of the register being written
    do_write(5'd3, 64'd1);
    we = 1'b1; waddr = 5'd3; wdata = 64'd7; raddr1 = 5'd3; raddr2 = 5'd3;
    push(0, 30, 64'd1); push(1, 31, 64'd1);
    step();
    we = 1'b0;
    push(0, 32, 64'd7); push(1, 33, 64'd7);
    step();
    push(0, 34, 64'd7);
    step();

    // ALU directed
    alu_case(40, 2'b01, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFC, 64'h000000007FFFFFFC);
    alu_case(41, 2'b01, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0);
    alu_case(42, 2'b10, 64'd3, 64'd5, 64'd1);
    alu_case(43, 2'b10, 64'd5, 64'd3, 64'd0);
    alu_case(44, 2'b10, 64'd5, 64'd5, 64'd0);
    alu_case(45, 2'b10, 64'd1, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    alu_case(46, 2'b00, 64'hAAAA, 64'hAAAA, 64'd0);
    alu_case(47, 2'b11, 64'hAAAA, 64'hAAAA, 64'd0);

    // Fill every writable register with its index, then read all on both ports
    for (int i = 0; i < 32; i++) do_write(5'(i), 64'(i));
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      push(0, 100 + i, 64'(i));
      push(1, 200 + i, 64'(31 - i));
      step();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: a = a >> $urandom_range(0, 63);
        default: ;
      endcase
      aluop = 2'($urandom_range(0, 3));
      alu_src1 = a; alu_src2 = b;
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = {$urandom, $urandom};
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      exp_rd1(1000 + n); exp_rd2(2000 + n); exp_alu(3000 + n);
      step();
    end
    we = 1'b0;

    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
